div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative 32-step radix-2 divider core.
- Accepts a divide request from EX and stalls the pipeline while the core runs.
- Short-circuits divide-by-zero, aborts on pipeline annul or timeout, and delivers HI/LO with a single-cycle write enable.
- Makes the divider a clean start/done resource; no combinational latch-style sequencing.

Parameters:
DATA_W, 32, operand/result width
TIMEOUT, 40, max BUSY cycles before forced abort (must exceed core latency of 33)
CNT_W, 6, width of BUSY cycle counter (2^CNT_W > TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
div_req  in  1  EX holds a DIV/DIVU instruction (level, held while stalled)
div_signed  in  1  1 = DIV, 0 = DIVU
opdata1  in  DATA_W  dividend
opdata2  in  DATA_W  divisor
annul  in  1  flush of EX instruction (exception/branch kill)
core_start  out  1  one-cycle start pulse to divider core
core_signed  out  1  registered signedness to core
core_dividend  out  DATA_W  registered dividend
core_divisor  out  DATA_W  registered divisor
core_cancel  out  1  one-cycle abort pulse to core
core_done  in  1  core result valid (one-cycle pulse)
core_quo  in  DATA_W  quotient
core_rem  in  DATA_W  remainder
hi_o  out  DATA_W  remainder to HI
lo_o  out  DATA_W  quotient to LO
whilo_o  out  1  HI/LO write enable, one cycle
stallreq  out  1  pipeline stall request (combinational)
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst=1): state=IDLE; counter=0; all outputs 0 (hi_o, lo_o, whilo_o, core_*, timeout_o). stallreq=0.
- States: IDLE, BUSY, DONE.
- stallreq = (IDLE & div_req & !annul) | BUSY. Always 0 in DONE.
- IDLE, div_req & !annul:
  - opdata2==0: hi_o=lo_o=0 registered; -> DONE. Total stall 1 cycle.
  - otherwise: latch operands and div_signed into core_* registers; core_start=1 on the first BUSY cycle only; counter=0; -> BUSY.
- IDLE, annul or no div_req: stay IDLE; no outputs.
- BUSY: counter increments every cycle.
  - core_done: capture hi_o=core_rem, lo_o=core_quo; -> DONE.
  - annul (priority over core_done): core_cancel=1 for one cycle; -> IDLE; no HI/LO write.
  - counter==TIMEOUT-1 without core_done: core_cancel=1, timeout_o=1 for one cycle; -> IDLE; no write. EX re-requests next cycle if div_req is still high.
- DONE: whilo_o=1 for exactly this cycle unless annul=1 (then 0). div_req is ignored (it belongs to the completing instruction). Always -> IDLE.
- Back-to-back divides: the next request is accepted in the IDLE cycle after DONE; minimum spacing 2 cycles.
- Signed overflow (0x80000000 / -1) is passed to the core unchanged; the result is whatever the core returns.
- hi_o/lo_o hold their last value outside DONE; only whilo_o qualifies them.
- Reset asserted mid-BUSY: immediate return to IDLE. No core_cancel pulse; the core is reset by the same rst.

Decomposition:
- Shared defines header gets: state encodings DivIdle/DivBusy/DivDone, DivTimeout default, and StallReq/NotStall alongside the existing Stop/WriteEnable macros.
- No sub-module. The watchdog counter is inline.
- The divider core is a separate existing-style instance connected by the top EX wrapper.

Test Plan:
- Unsigned 100/7, core returns done after 33 cycles -> core_start pulse with dividend 100, divisor 7; stallreq high 34 cycles; DONE cycle whilo_o=1, lo_o=14, hi_o=2.
- Divisor 0, opdata1=0x1234 -> no core_start; stallreq high 1 cycle; next cycle whilo_o=1, hi_o=lo_o=0.
- annul at BUSY cycle 10 -> core_cancel pulse in that cycle, stallreq drops next cycle, whilo_o never asserts.
- Core never asserts done -> at BUSY cycle 40, timeout_o=1 and core_cancel=1; state IDLE; re-request issues a fresh core_start.
- Two consecutive DIVs (-7/2 signed, core returns quo=0xFFFFFFFD, rem=0xFFFFFFFF, then 9/3 = 3 r 0) -> two whilo_o pulses with matching hi/lo; second core_start is exactly 2 cycles after the first DONE.
- Async rst asserted mid-BUSY, between clock edges -> all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
// div_seq_ctrl_pkg
//   Shared definitions for the divider sequencing controller.
//   - FSM state encodings: DivIdle / DivBusy / DivDone
//   - DivTimeout: default watchdog limit in BUSY cycles. It must exceed
//     the 33-cycle core latency.
//   - Single-bit control constants: StallReq/NotStall, WriteEnable/WriteDisable,
//     and Stop/NoStop.
package div_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    DivIdle = 2'b00,
    DivBusy = 2'b01,
    DivDone = 2'b10
  } div_state_e;

  localparam int   DivTimeout   = 40;

  localparam logic StallReq     = 1'b1;
  localparam logic NotStall     = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if
//   Start/done handshake between the sequencing controller and the
//   iterative divider core.
//   master (controller): drives core_start, core_signed, core_dividend,
//                        core_divisor and core_cancel; samples core_done,
//                        core_quo and core_rem.
//   slave  (core)      : the mirror image of master.
interface div_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              core_start;
  logic              core_signed;
  logic [DATA_W-1:0] core_dividend;
  logic [DATA_W-1:0] core_divisor;
  logic              core_cancel;
  logic              core_done;
  logic [DATA_W-1:0] core_quo;
  logic [DATA_W-1:0] core_rem;

  modport master (
    output core_start, core_signed, core_dividend, core_divisor, core_cancel,
    input  core_done, core_quo, core_rem
  );

  modport slave (
    input  core_start, core_signed, core_dividend, core_divisor, core_cancel,
    output core_done, core_quo, core_rem
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
//   This module sequences a divide between the EX stage and a 32-step radix-2
//   divider core. It accepts a DIV/DIVU request and stalls the pipeline while
//   the core runs.
//   A zero divisor bypasses the core and returns 0 in HI and in LO. An annul
//   or the watchdog aborts the operation with a one-cycle cancel pulse.
//   The result goes to HI and LO with a one-cycle write enable.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   div_req, div_signed   EX request level and signedness
//   opdata1, opdata2      dividend and divisor
//   annul                 flush of the EX instruction
//   core (master)         start/cancel/operands out; done/quo/rem in
//   hi_o, lo_o            remainder and quotient, held between writes
//   whilo_o               one-cycle HI/LO write enable
//   stallreq              combinational pipeline stall request
//   timeout_o             one-cycle pulse when the watchdog aborts
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DivTimeout,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_req,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  input  logic              annul,
  div_seq_ctrl_if.master    core,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o,
  output logic              stallreq,
  output logic              timeout_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  div_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              core_start_reg;
  logic              core_signed_reg;
  logic [DATA_W-1:0] dividend_reg, divisor_reg;
  logic [DATA_W-1:0] hi_reg, lo_reg;

  logic accept, zero_div, capture, cancel, timeout, whilo, stall;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= DivIdle;
    else     state_reg <= state_next;
  end

  // Next-state logic and the single-cycle controls derived from it
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    zero_div   = 1'b0;
    capture    = 1'b0;
    cancel     = NoStop;
    timeout    = 1'b0;
    whilo      = WriteDisable;
    stall      = NotStall;
    case (state_reg)
      DivIdle: begin
        if (div_req && !annul) begin
          stall = StallReq;
          if (opdata2 == '0) begin
            zero_div   = 1'b1;
            state_next = DivDone;
          end else begin
            accept     = 1'b1;
            state_next = DivBusy;
          end
        end
      end
      DivBusy: begin
        stall = StallReq;
        // annul takes priority, so a flushed instruction never writes HI or LO
        if (annul) begin
          cancel     = Stop;
          state_next = DivIdle;
        end else if (core.core_done) begin
          capture    = 1'b1;
          state_next = DivDone;
        end else if (cnt_reg == CntLast) begin
          cancel     = Stop;
          timeout    = 1'b1;
          state_next = DivIdle;
        end
      end
      DivDone: begin
        // div_req here still belongs to the completing instruction
        whilo      = annul ? WriteDisable : WriteEnable;
        state_next = DivIdle;
      end
      default: state_next = DivIdle;
    endcase
  end

  // Operand latches, watchdog counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg         <= '0;
      core_start_reg  <= 1'b0;
      core_signed_reg <= 1'b0;
      dividend_reg    <= '0;
      divisor_reg     <= '0;
      hi_reg          <= '0;
      lo_reg          <= '0;
    end else begin
      // The start pulse lands on the first BUSY cycle
      core_start_reg <= accept;
      // Counter reads 0 in the first BUSY cycle and TIMEOUT-1 in the last one
      cnt_reg <= (state_reg == DivBusy) ? cnt_reg + CNT_W'(1) : '0;
      if (accept) begin
        core_signed_reg <= div_signed;
        dividend_reg    <= opdata1;
        divisor_reg     <= opdata2;
      end
      if (zero_div) begin
        hi_reg <= '0;
        lo_reg <= '0;
      end else if (capture) begin
        hi_reg <= core.core_rem;
        lo_reg <= core.core_quo;
      end
    end
  end

  assign core.core_start    = core_start_reg;
  assign core.core_signed   = core_signed_reg;
  assign core.core_dividend = dividend_reg;
  assign core.core_divisor  = divisor_reg;
  assign core.core_cancel   = cancel;

  assign hi_o      = hi_reg;
  assign lo_o      = lo_reg;
  assign whilo_o   = whilo;
  assign timeout_o = timeout;
  // The IDLE term is combinational on div_req. Gate it with rst so the stall
  // request is held low while reset is asserted.
  assign stallreq  = stall & ~rst;

endmodule
